fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised prefetching instruction fetch unit. It is the successor to the single-byte fetcher.
- Streams sequential bytes from the synchronous program memory into a byte queue of DEPTH entries.
- Decodes 6502 instruction length from the head opcode and presents a complete instruction (opcode plus 0–2 operands) to the decoder over a valid/ready handshake.
- Supports pipeline flush and redirect for jumps, branches and interrupts.

Parameters:
- ADDR_WIDTH, 16, width of fetch address and PC.
- DATA_WIDTH, 8, width of a memory byte / queue entry.
- DEPTH, 4, queue entries in bytes; legal range 3..16, not required to be a power of two.
- RESET_PC, 16'h0010, first fetch address after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_rd  out  1  read request this cycle.
- mem_addr  out  ADDR_WIDTH  read address; valid when mem_rd=1.
- mem_data  in  DATA_WIDTH  read data; valid exactly one cycle after the mem_rd cycle.
- instr_valid  out  1  a complete instruction is at the queue head.
- instr_ready  in  1  decoder accepts the head instruction.
- instr_op  out  DATA_WIDTH  opcode byte (queue head).
- instr_op1  out  DATA_WIDTH  operand byte 1; 0 when instr_len<2.
- instr_op2  out  DATA_WIDTH  operand byte 2; 0 when instr_len<3.
- instr_len  out  2  instruction length, 1..3; 0 when instr_valid=0.
- instr_pc  out  ADDR_WIDTH  address of the opcode byte.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_WIDTH  new fetch address.
- count  out  clog2(DEPTH+1)  bytes currently held.

Behaviour:
- Reset (async, reset_n=0):
  - fetch_addr=RESET_PC, head_pc=RESET_PC.
  - count=0, inflight=0, pointers=0, mem_rd=0.
  - All instr_* outputs=0.
- Reset deasserted in the middle of a read: the data returned for the pre-reset read is ignored.
- Read issue:
  - mem_rd=1 when (count + inflight + push_pending_adjust) < DEPTH and redirect=0.
  - A pop in the same cycle is not credited until the next cycle.
  - mem_addr=fetch_addr. fetch_addr increments by 1 per issued read and wraps modulo 2^ADDR_WIDTH (FFFF -> 0000).
- Data return:
  - inflight (1 bit) is set in the cycle after mem_rd=1.
  - In that cycle mem_data is pushed at the tail, unless it is discarded.
  - Latency from mem_rd to the byte being visible in the queue: 2 cycles.
- Length rule (opcode o, low nibble n, bit b4 = o[4]):
  - len=1: n==8; n==A; o==00; o==40; o==60.
  - len=3: n in {C,D,E,F}; n in {9,B} with b4=1; o==20.
  - len=2: all other opcodes, including illegal ones.
- Output presentation:
  - instr_valid=1 when count >= len(head).
  - instr_op, instr_op1, instr_op2 and instr_len are combinational from the queue head.
  - instr_pc = head_pc (registered).
- Pop:
  - On instr_valid & instr_ready, remove len bytes and set head_pc += len (mod 2^ADDR_WIDTH).
  - A push and a pop in the same cycle are both applied; new count = count + push - len.
  - instr_ready while instr_valid=0 has no effect.
- Full: when count==DEPTH, mem_rd=0. A full queue never overflows because issue reserves space for inflight data.
- Redirect (highest priority):
  - Next cycle: count=0, pointers reset, head_pc=redirect_pc, fetch_addr=redirect_pc.
  - Any inflight byte returning in the next cycle is discarded (one-cycle drop flag).
  - mem_rd=0 in the redirect cycle.
  - A valid&ready handshake in the same cycle counts as completed; the decoder owns its consequences.
  - Back-to-back redirects: the last one wins.
- Steady state:
  - With instr_ready=1 held and DEPTH>=4, throughput is 1 byte/cycle.
  - No bubble between consecutive 1-byte instructions once the queue is primed.

Test Plan:
- Program at 0010: A9 04 85 02, hold instr_ready=0.
  - mem_rd in cycles 0..3 after reset release.
  - instr_valid rises in cycle 3 with op=A9, op1=04, len=2, pc=0010.
  - count saturates at 4 and mem_rd drops.
- Same program, then ready=1 for 2 cycles.
  - Second instruction is op=85, op1=02, len=2, pc=0012.
  - Then instr_valid=0 until further bytes (EA...) arrive.
- Mixed lengths E8, 4C 34 12, 0A.
  - Lengths 1, 3, 1; pcs 0010, 0011, 0014.
  - For 4C: op1=34, op2=12; op2=0 for the 1-byte opcodes.
- Redirect to 0200 asserted with a read inflight and count=3.
  - Next cycle count=0, the inflight byte is dropped, mem_addr=0200, and the first instr_pc becomes 0200.
- Wrap: redirect_pc=FFFE, memory FFFE=20, FFFF=00, 0000=80.
  - mem_addr sequence FFFE, FFFF, 0000.
  - Instruction JSR len=3 with op1=00, op2=80.
  - head_pc then = 0001.
- Async reset asserted mid-stream with count=2.
  - Outputs clear immediately with no clock edge.
  - After release, fetch restarts at 0010.

Source files
------------

// File: rtl/fetch_queue.sv
// Prefetching 6502 instruction fetch unit: streams program bytes into a DEPTH-entry
// byte queue and presents whole instructions (opcode + 0..2 operands) to the decoder.
module fetch_queue #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 16'h0010
) (
    input  logic                          clk,
    input  logic                          reset_n,
    output logic                          mem_rd,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0]         mem_data,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [DATA_WIDTH-1:0]         instr_op,
    output logic [DATA_WIDTH-1:0]         instr_op1,
    output logic [DATA_WIDTH-1:0]         instr_op2,
    output logic [1:0]                    instr_len,
    output logic [ADDR_WIDTH-1:0]         instr_pc,
    input  logic                          redirect,
    input  logic [ADDR_WIDTH-1:0]         redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_P = (PW+1)'(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] queue [DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic                  inflight, drop;
    logic [ADDR_WIDTH-1:0] fetch_addr, head_pc;

    logic [DATA_WIDTH-1:0] hd0, hd1, hd2;
    logic [1:0]            head_len, pop_len;
    logic                  push, pop;
    logic [CW:0]           reserved, count_next;

    // Pointer advance modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        logic [PW:0] s;
        s = {1'b0, p} + (PW+1)'(n);
        if (s >= DEPTH_P)
            s = s - DEPTH_P;
        return s[PW-1:0];
    endfunction

    function automatic logic [1:0] op_len(input logic [7:0] o);
        logic [3:0] n;
        n = o[3:0];
        if (n == 4'h8 || n == 4'hA || o == 8'h00 || o == 8'h40 || o == 8'h60)
            return 2'd1;
        else if (n >= 4'hC || ((n == 4'h9 || n == 4'hB) && o[4]) || o == 8'h20)
            return 2'd3;
        else
            return 2'd2;
    endfunction

    assign hd0      = queue[rd_ptr];
    assign hd1      = queue[ptr_add(rd_ptr, 2'd1)];
    assign hd2      = queue[ptr_add(rd_ptr, 2'd2)];
    assign head_len = op_len(hd0[7:0]);

    // len is never 0, so count >= len also implies a non-empty queue.
    assign instr_valid = (count >= CW'(head_len));
    assign instr_op    = instr_valid ? hd0 : '0;
    assign instr_op1   = (instr_valid && head_len >= 2'd2) ? hd1 : '0;
    assign instr_op2   = (instr_valid && head_len == 2'd3) ? hd2 : '0;
    assign instr_len   = instr_valid ? head_len : 2'd0;
    assign instr_pc    = instr_valid ? head_pc : '0;

    assign push    = inflight & ~drop;
    assign pop     = instr_valid & instr_ready;
    assign pop_len = pop ? head_len : 2'd0;

    // Space is reserved for the byte still in flight; pops are credited a cycle later.
    assign reserved   = {1'b0, count} + (CW+1)'(inflight);
    assign mem_rd     = reset_n && !redirect && (reserved < DEPTH_C);
    assign mem_addr   = fetch_addr;
    assign count_next = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop_len);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_addr <= RESET_PC;
            head_pc    <= RESET_PC;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            inflight   <= 1'b0;
            drop       <= 1'b0;
        end else begin
            inflight <= mem_rd;
            drop     <= redirect;
            if (redirect) begin
                count      <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                head_pc    <= redirect_pc;
                fetch_addr <= redirect_pc;
            end else begin
                count <= count_next[CW-1:0];
                if (push)
                    wr_ptr <= ptr_add(wr_ptr, 2'd1);
                if (pop) begin
                    rd_ptr  <= ptr_add(rd_ptr, head_len);
                    head_pc <= head_pc + ADDR_WIDTH'(head_len);
                end
                if (mem_rd)
                    fetch_addr <= fetch_addr + 1'b1;
            end
        end
    end

    // Queue storage carries data only and is left out of reset.
    always_ff @(posedge clk) begin
        if (push)
            queue[wr_ptr] <= mem_data;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: cycle-exact vector table plus hand-written
// sequences for mixed lengths, redirect, address wrap and async reset.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [7:0]  instr_op, instr_op1, instr_op2;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:65535];

    fetch_queue #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .DEPTH(4), .RESET_PC(16'h0010)) dut (
        .clk(clk), .reset_n(reset_n), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_data(mem_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_op1(instr_op1), .instr_op2(instr_op2),
        .instr_len(instr_len), .instr_pc(instr_pc), .redirect(redirect),
        .redirect_pc(redirect_pc), .count(count)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: data appears the cycle after the read request.
    always @(posedge clk) begin
        if (mem_rd)
            mem_data <= mem[mem_addr];
    end

    typedef struct {
        logic        ready;
        logic        exp_rd;
        logic [15:0] exp_addr;
        logic        exp_valid;
        logic [7:0]  exp_op;
        logic [7:0]  exp_op1;
        logic [1:0]  exp_len;
        logic [15:0] exp_pc;
        logic [2:0]  exp_count;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic load_mem(input logic [15:0] base, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
        mem[base]       = b0;
        mem[base + 16'd1] = b1;
        mem[base + 16'd2] = b2;
        mem[base + 16'd3] = b3;
        mem[base + 16'd4] = b4;
    endtask

    task automatic fill_nops();
        for (int a = 0; a < 65536; a++)
            mem[a] = 8'hEA;
    endtask

    // Leaves the bench at a falling edge with reset just released (start of cycle 0).
    task automatic do_reset();
        reset_n     = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Waits (bounded) for a valid instruction with instr_ready held by the caller.
    task automatic take(input string name, input logic [7:0] op, input logic [7:0] op1,
                        input logic [7:0] op2, input logic [1:0] len, input logic [15:0] pc);
        bit got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            #1;
            if (instr_valid)
                got = 1'b1;
        end
        if (!got) begin
            chk({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({name, "_op"},  {24'd0, instr_op},  {24'd0, op});
            chk({name, "_op1"}, {24'd0, instr_op1}, {24'd0, op1});
            chk({name, "_op2"}, {24'd0, instr_op2}, {24'd0, op2});
            chk({name, "_len"}, {30'd0, instr_len}, {30'd0, len});
            chk({name, "_pc"},  {16'd0, instr_pc},  {16'd0, pc});
        end
    endtask

    initial begin
        //           ready rd   addr      vld op     op1    len   pc        cnt
        vecs[0] = '{1'b0, 1'b1, 16'h0010, 1'b0, 8'h00, 8'h00, 2'd0, 16'h0000, 3'd0};
        vecs[1] = '{1'b0, 1'b1, 16'h0011, 1'b0, 8'h00, 8'h00, 2'd0, 16'h0000, 3'd0};
        vecs[2] = '{1'b1, 1'b1, 16'h0012, 1'b0, 8'h00, 8'h00, 2'd0, 16'h0000, 3'd1};
        vecs[3] = '{1'b0, 1'b1, 16'h0013, 1'b1, 8'hA9, 8'h04, 2'd2, 16'h0010, 3'd2};
        vecs[4] = '{1'b0, 1'b0, 16'h0000, 1'b1, 8'hA9, 8'h04, 2'd2, 16'h0010, 3'd3};
        vecs[5] = '{1'b0, 1'b0, 16'h0000, 1'b1, 8'hA9, 8'h04, 2'd2, 16'h0010, 3'd4};
        vecs[6] = '{1'b1, 1'b0, 16'h0000, 1'b1, 8'hA9, 8'h04, 2'd2, 16'h0010, 3'd4};
        vecs[7] = '{1'b1, 1'b1, 16'h0014, 1'b1, 8'h85, 8'h02, 2'd2, 16'h0012, 3'd2};
        vecs[8] = '{1'b0, 1'b1, 16'h0015, 1'b0, 8'h00, 8'h00, 2'd0, 16'h0000, 3'd0};
        vecs[9] = '{1'b0, 1'b1, 16'h0016, 1'b1, 8'hEA, 8'h00, 2'd1, 16'h0014, 3'd1};

        // Reset state while reset_n is held low
        @(negedge clk);
        #1;
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);

        // Cycle-exact table: priming, saturation, two pops, refill with NOPs
        fill_nops();
        load_mem(16'h0010, 8'hA9, 8'h04, 8'h85, 8'h02, 8'hEA);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            instr_ready = vecs[i].ready;
            #1;
            chk($sformatf("v%0d_mem_rd", i), {31'd0, mem_rd}, {31'd0, vecs[i].exp_rd});
            if (vecs[i].exp_rd)
                chk($sformatf("v%0d_addr", i), {16'd0, mem_addr}, {16'd0, vecs[i].exp_addr});
            chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("v%0d_op", i), {24'd0, instr_op}, {24'd0, vecs[i].exp_op});
            chk($sformatf("v%0d_op1", i), {24'd0, instr_op1}, {24'd0, vecs[i].exp_op1});
            chk($sformatf("v%0d_op2", i), {24'd0, instr_op2}, 32'd0);
            chk($sformatf("v%0d_len", i), {30'd0, instr_len}, {30'd0, vecs[i].exp_len});
            chk($sformatf("v%0d_pc", i), {16'd0, instr_pc}, {16'd0, vecs[i].exp_pc});
            chk($sformatf("v%0d_count", i), {29'd0, count}, {29'd0, vecs[i].exp_count});
            @(negedge clk);
        end

        // Mixed instruction lengths with the decoder always ready
        fill_nops();
        load_mem(16'h0010, 8'hE8, 8'h4C, 8'h34, 8'h12, 8'h0A);
        do_reset();
        instr_ready = 1'b1;
        take("mix_inx", 8'hE8, 8'h00, 8'h00, 2'd1, 16'h0010);
        take("mix_jmp", 8'h4C, 8'h34, 8'h12, 2'd3, 16'h0011);
        take("mix_asl", 8'h0A, 8'h00, 8'h00, 2'd1, 16'h0014);

        // Redirect with count=3 and a read in flight
        fill_nops();
        load_mem(16'h0010, 8'hA9, 8'h04, 8'h85, 8'h02, 8'hEA);
        mem[16'h0200] = 8'h18;
        do_reset();
        repeat (4) @(negedge clk);
        #1;
        chk("redir_pre_count", {29'd0, count}, 32'd3);
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        #1;
        chk("redir_mem_rd_low", {31'd0, mem_rd}, 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("redir_count", {29'd0, count}, 32'd0);
        chk("redir_mem_rd", {31'd0, mem_rd}, 32'd1);
        chk("redir_addr", {16'd0, mem_addr}, 32'h0200);
        @(negedge clk);
        #1;
        chk("redir_dropped", {29'd0, count}, 32'd0);
        instr_ready = 1'b1;
        take("redir_first", 8'h18, 8'h00, 8'h00, 2'd1, 16'h0200);

        // Address wrap across FFFF -> 0000
        @(negedge clk);
        instr_ready = 1'b0;
        mem[16'hFFFE] = 8'h20;
        mem[16'hFFFF] = 8'h00;
        mem[16'h0000] = 8'h80;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("wrap_addr0", {15'd0, mem_rd, mem_addr}, 32'h1FFFE);
        @(negedge clk);
        #1;
        chk("wrap_addr1", {15'd0, mem_rd, mem_addr}, 32'h1FFFF);
        @(negedge clk);
        #1;
        chk("wrap_addr2", {15'd0, mem_rd, mem_addr}, 32'h10000);
        instr_ready = 1'b1;
        take("wrap_jsr", 8'h20, 8'h00, 8'h80, 2'd3, 16'hFFFE);
        take("wrap_next", 8'hEA, 8'h00, 8'h00, 2'd1, 16'h0001);

        // Asynchronous reset mid-stream with two bytes queued
        fill_nops();
        load_mem(16'h0010, 8'hA9, 8'h04, 8'h85, 8'h02, 8'hEA);
        do_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("areset_pre_count", {29'd0, count}, 32'd2);
        #1;
        reset_n = 1'b0;
        #1;
        chk("areset_count", {29'd0, count}, 32'd0);
        chk("areset_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("areset_valid", {31'd0, instr_valid}, 32'd0);
        chk("areset_instr", {instr_op, instr_op1, instr_op2, 6'd0, instr_len}, 32'd0);
        chk("areset_pc", {16'd0, instr_pc}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("areset_restart", {15'd0, mem_rd, mem_addr}, 32'h10010);
        instr_ready = 1'b1;
        take("areset_first", 8'hA9, 8'h04, 8'h00, 2'd2, 16'h0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
